// File: rtl/mem_access.sv
// Load/store initiator for a 1-cycle-latency word memory: aligned access responds 3 cycles after accept; READY only in IDLE.
// Misaligned access splits into two word cycles when MEM_ACCESS_UNALIGNED_SPLIT_EN is defined, otherwise it is rejected with RSP_ERR_ALIGN.
module mem_access #(
    parameter int ADDR_W = 30
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_SIGNED,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WD,
    input  logic              KILL,
    output logic              READY,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_DATA,
    output logic              RSP_ERR_DBE,
    output logic              RSP_ERR_ALIGN,
    output logic [ADDR_W-1:0] D_ADDR,
    output logic              D_RE,
    output logic              D_WE,
    output logic [3:0]        D_BE,
    output logic [31:0]       D_WD,
    input  logic [31:0]       D_RD,
    input  logic              D_DBE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_off;
    logic              r_split;
    logic [3:0]        r_be2;
    logic [31:0]       r_wd2;
    logic [31:0]       r_rd1;
    logic              r_dbe;
    logic [ADDR_W-1:0] r_d_addr;
    logic              r_d_re;
    logic              r_d_we;
    logic [3:0]        r_d_be;
    logic [31:0]       r_d_wd;
    logic              r_rsp_vld;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_dbe;
    logic              r_rsp_align;

    logic [1:0]        w_off;
    logic [3:0]        w_base_be;
    logic              w_misalign;
    logic [31:0]       w_wd_sz;
    logic [7:0]        w_be8;
    logic [63:0]       w_wd64;
    logic              w_split;
    logic              w_align_err;
    logic [63:0]       w_merge;
    logic [31:0]       w_ext;
    logic [31:0]       w_load;
    logic              w_rsp_dbe;

    assign w_off = REQ_ADDR[1:0];

    always_comb begin
        w_base_be  = 4'b1111;
        w_misalign = (w_off != 2'b00);
        w_wd_sz    = REQ_WD;
        case (REQ_SIZE)
            2'b00: begin
                w_base_be  = 4'b0001;
                w_misalign = 1'b0;
                w_wd_sz    = {24'h0, REQ_WD[7:0]};
            end
            2'b01: begin
                w_base_be  = 4'b0011;
                w_misalign = w_off[0];
                w_wd_sz    = {16'h0, REQ_WD[15:0]};
            end
            default: ;
        endcase
    end

    // Lanes 7:4 / bits 63:32 spill into the following word for split accesses
    assign w_be8  = {4'h0, w_base_be} << w_off;
    assign w_wd64 = {32'h0, w_wd_sz} << {w_off, 3'b000};

`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
    assign w_split     = w_misalign;
    assign w_align_err = 1'b0;
`else
    assign w_split     = 1'b0;
    assign w_align_err = w_misalign;
`endif

    assign w_merge   = r_split ? {D_RD, r_rd1} : {32'h0, D_RD};
    assign w_ext     = w_merge[{r_off, 3'b000} +: 32];
    assign w_rsp_dbe = r_dbe | D_DBE;

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_ext[7]}}, w_ext[7:0]};
            2'b01:   w_load = {{16{r_signed & w_ext[15]}}, w_ext[15:0]};
            default: w_load = w_ext;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_off       <= 2'b00;
            r_split     <= 1'b0;
            r_be2       <= 4'h0;
            r_wd2       <= 32'h0;
            r_rd1       <= 32'h0;
            r_dbe       <= 1'b0;
            r_d_addr    <= '0;
            r_d_re      <= 1'b0;
            r_d_we      <= 1'b0;
            r_d_be      <= 4'h0;
            r_d_wd      <= 32'h0;
            r_rsp_vld   <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_dbe   <= 1'b0;
            r_rsp_align <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_we     <= REQ_WE;
                        r_size   <= REQ_SIZE;
                        r_signed <= REQ_SIGNED;
                        r_off    <= w_off;
                        r_split  <= w_split;
                        r_dbe    <= 1'b0;
                        if (w_align_err) begin
                            r_rsp_vld   <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_dbe   <= 1'b0;
                            r_rsp_align <= 1'b1;
                        end else begin
                            r_state  <= S_ACC;
                            r_d_addr <= REQ_ADDR[ADDR_W+1:2];
                            r_d_re   <= ~REQ_WE;
                            r_d_we   <= REQ_WE;
                            r_d_be   <= w_be8[3:0];
                            r_d_wd   <= w_wd64[31:0];
                            r_be2    <= w_be8[7:4];
                            r_wd2    <= w_wd64[63:32];
                        end
                    end
                end
                S_ACC: begin
                    if (!KILL && r_split) begin
                        r_state  <= S_ACC2;
                        r_d_addr <= r_d_addr + ADDR_W'(1);
                        r_d_be   <= r_be2;
                        r_d_wd   <= r_wd2;
                    end else begin
                        r_state <= KILL ? S_IDLE : S_RESP;
                        r_d_re  <= 1'b0;
                        r_d_we  <= 1'b0;
                        r_d_be  <= 4'h0;
                    end
                end
                S_ACC2: begin
                    r_rd1   <= D_RD;
                    r_dbe   <= D_DBE;
                    r_state <= KILL ? S_IDLE : S_RESP;
                    r_d_re  <= 1'b0;
                    r_d_we  <= 1'b0;
                    r_d_be  <= 4'h0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_vld   <= 1'b1;
                    r_rsp_dbe   <= w_rsp_dbe;
                    r_rsp_align <= 1'b0;
                    r_rsp_data  <= (r_we || w_rsp_dbe) ? 32'h0 : w_load;
                end
            endcase
        end
    end

    // A part-1 bus error arrives during ACC2 and must block the part-2 write
    assign D_WE          = r_d_we & ~KILL & ~((r_state == S_ACC2) & D_DBE);
    assign D_RE          = r_d_re;
    assign D_BE          = r_d_be;
    assign D_ADDR        = r_d_addr;
    assign D_WD          = r_d_wd;
    assign READY         = (r_state == S_IDLE);
    assign RSP_VALID     = r_rsp_vld;
    assign RSP_DATA      = r_rsp_data;
    assign RSP_ERR_DBE   = r_rsp_dbe;
    assign RSP_ERR_ALIGN = r_rsp_align;

endmodule
